// File: rtl/noc_output_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// noc_output_port_arbiter_if : input-side and output-side flit handshakes of one router output port
// Rev 1.0
// ============================================================================
interface noc_output_port_arbiter_if #(
  parameter int NUM_REQ = 5,
  parameter int FLIT_W  = 64
);
  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ-1:0]        in_head;
  logic [NUM_REQ-1:0]        in_tail;
  logic [NUM_REQ*FLIT_W-1:0] in_flit;
  logic [NUM_REQ-1:0]        in_ready;
  logic                      out_valid;
  logic [FLIT_W-1:0]         out_flit;
  logic                      out_ready;

  modport master (
    output in_valid, in_head, in_tail, in_flit, out_ready,
    input  in_ready, out_valid, out_flit
  );

  modport slave (
    input  in_valid, in_head, in_tail, in_flit, out_ready,
    output in_ready, out_valid, out_flit
  );
endinterface
`default_nettype wire

// File: rtl/noc_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// noc_output_port_arbiter : wormhole round-robin arbiter and flit mux for one output link
// Optional stall watchdog enabled by defining NOC_ARB_WATCHDOG_EN.      Rev 1.0
// ============================================================================
module noc_output_port_arbiter #(
  parameter int NUM_REQ     = 5,
  parameter int FLIT_W      = 64,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  noc_output_port_arbiter_if.slave  port,
  output logic [NUM_REQ-1:0]        grant_oh,
  output logic                      wdog_err
);

  localparam int              PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt, w_cand;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt, r_rr_ptr, w_rr_ptr_nxt, w_win, w_owner_inc;
  logic [PTR_W:0]     w_idx;
  logic               w_found, w_fire, w_owner_valid, w_owner_tail, w_wdog_fire;
  logic [FLIT_W-1:0]  w_flits [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_flits[i] = port.in_flit[i*FLIT_W +: FLIT_W];
  end

  assign w_owner_valid = port.in_valid[r_owner];
  assign w_owner_tail  = port.in_tail[r_owner];
  assign w_fire        = (r_state == ST_LOCKED) && w_owner_valid && port.out_ready;
  assign w_owner_inc   = (r_owner == LAST_IDX) ? '0 : r_owner + PTR_W'(1);
  assign w_cand        = port.in_valid & port.in_head;
  assign grant_oh      = r_grant;

  // Output side is driven straight from the registered owner, so a flit can move every cycle of a lock.
  always_comb begin
    port.out_valid = 1'b0;
    port.out_flit  = '0;
    port.in_ready  = '0;
    if (r_state == ST_LOCKED) begin
      port.out_valid = w_owner_valid;
      port.out_flit  = w_flits[r_owner];
      port.in_ready  = r_grant & {NUM_REQ{port.out_ready}};
    end
  end

  // Round-robin search: first head at or after rr_ptr, wrapping explicitly at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!w_found && w_cand[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_win;
          w_grant_nxt = NUM_REQ'(1) << w_win;
        end
      end
      ST_LOCKED: begin
        if ((w_fire && w_owner_tail) || w_wdog_fire) begin
          w_state_nxt  = ST_IDLE;
          w_grant_nxt  = '0;
          w_rr_ptr_nxt = w_owner_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_err;

  // Release on the stall cycle that brings the count to WDOG_CYCLES; the pulse lands with grant_oh=0.
  assign w_wdog_fire = (r_state == ST_LOCKED) && !w_owner_valid &&
                       (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog_err <= w_wdog_fire;
      if ((r_state != ST_LOCKED) || w_owner_valid || w_wdog_fire) begin
        r_wdog_cnt <= '0;
      end else begin
        r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
      end
    end
  end

  assign wdog_err = r_wdog_err;
`else
  logic [31:0] w_unused_wdog_cycles;

  assign w_unused_wdog_cycles = WDOG_CYCLES;
  assign w_wdog_fire          = 1'b0;
  assign wdog_err             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_noc_output_port_arbiter : directed scenarios plus randomized traffic against a packet-level model
// Rev 1.0
// ============================================================================
module tb_noc_output_port_arbiter;

  localparam int N  = 5;
  localparam int W  = 64;
  localparam int WD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_output_port_arbiter_if #(.NUM_REQ(N), .FLIT_W(W)) bus ();
  logic [N-1:0] grant_oh;
  logic         wdog_err;

  noc_output_port_arbiter #(.NUM_REQ(N), .FLIT_W(W), .WDOG_CYCLES(WD)) dut (
    .noc_clk  (clk),
    .noc_rst  (rst),
    .port     (bus),
    .grant_oh (grant_oh),
    .wdog_err (wdog_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid  = '0;
    bus.in_head   = '0;
    bus.in_tail   = '0;
    bus.in_flit   = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drive(input int i, input logic v, input logic h, input logic t, input logic [W-1:0] f);
    bus.in_valid[i]     = v;
    bus.in_head[i]      = h;
    bus.in_tail[i]      = t;
    bus.in_flit[i*W +: W] = f;
  endtask

  function automatic logic [W-1:0] flit_val(input int i, input int k);
    return {16'hF1A7, 16'(i), 32'(k)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, 1'b1, flit_val(i, 0));
    next_cycle();
    sample();
    checks++; if (grant_oh !== '0) begin errors++; $display("FAIL reset_grant: got %b want %b", grant_oh, 5'b0); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== '0) begin errors++; $display("FAIL reset_in_ready: got %b want %b", bus.in_ready, 5'b0); end
    checks++; if (bus.out_flit !== '0) begin errors++; $display("FAIL reset_out_flit: got %h want 0", bus.out_flit); end
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %b want 0", wdog_err); end
    idle_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_single_flit();
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b1, flit_val(0, 7));
    sample();
    checks++; if (grant_oh !== 5'b00000 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL sf_c0: got grant=%b ov=%b want grant=00000 ov=0", grant_oh, bus.out_valid); end
    next_cycle();
    sample();
    checks++; if (grant_oh !== 5'b00001) begin errors++; $display("FAIL sf_c1_grant: got %b want 00001", grant_oh); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== flit_val(0, 7)) begin
      errors++; $display("FAIL sf_c1_out: got ov=%b flit=%h want ov=1 flit=%h", bus.out_valid, bus.out_flit, flit_val(0, 7)); end
    checks++; if (bus.in_ready !== 5'b00001) begin errors++; $display("FAIL sf_c1_ready: got %b want 00001", bus.in_ready); end
    next_cycle();
    idle_inputs();
    drive(0, 1'b1, 1'b1, 1'b1, flit_val(0, 8));
    drive(1, 1'b1, 1'b1, 1'b1, flit_val(1, 8));
    sample();
    checks++; if (grant_oh !== 5'b00000 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL sf_c2_idle: got grant=%b ov=%b want grant=00000 ov=0", grant_oh, bus.out_valid); end
    next_cycle();
    sample();
    checks++; if (grant_oh !== 5'b00010 || bus.out_flit !== flit_val(1, 8)) begin
      errors++; $display("FAIL sf_c3_rrptr: got grant=%b flit=%h want grant=00010 flit=%h", grant_oh, bus.out_flit, flit_val(1, 8)); end
  endtask

  task automatic test_round_robin();
    int order [3] = '{0, 2, 4};
    logic [N-1:0] exp;
    int o;
    do_reset();
    foreach (order[j]) drive(order[j], 1'b1, 1'b1, 1'b1, flit_val(order[j], 1));
    for (int c = 0; c < 14; c++) begin
      sample();
      exp = '0;
      o = order[(c / 2) % 3];
      if (c % 2 == 1) exp[o] = 1'b1;
      checks++; if (grant_oh !== exp) begin errors++; $display("FAIL rr_grant c%0d: got %b want %b", c, grant_oh, exp); end
      if (c % 2 == 1) begin
        checks++; if (bus.out_flit !== flit_val(o, 1) || bus.in_ready !== exp) begin
          errors++; $display("FAIL rr_xfer c%0d: got flit=%h rdy=%b want flit=%h rdy=%b", c, bus.out_flit, bus.in_ready, flit_val(o, 1), exp); end
      end
      next_cycle();
    end
  endtask

  task automatic test_wormhole();
    logic [N-1:0] exp_g;
    do_reset();
    drive(3, 1'b1, 1'b1, 1'b1, flit_val(3, 0));
    for (int c = 0; c < 7; c++) begin
      case (c)
        0, 1:    drive(1, 1'b1, 1'b1, 1'b0, flit_val(1, 0));
        2:       drive(1, 1'b1, 1'b1, 1'b0, flit_val(1, 1));
        3:       drive(1, 1'b1, 1'b0, 1'b0, flit_val(1, 2));
        4:       drive(1, 1'b1, 1'b0, 1'b1, flit_val(1, 3));
        default: drive(1, 1'b0, 1'b0, 1'b0, '0);
      endcase
      sample();
      exp_g = (c >= 1 && c <= 4) ? 5'b00010 : (c == 6) ? 5'b01000 : 5'b00000;
      checks++; if (grant_oh !== exp_g || bus.in_ready !== exp_g) begin
        errors++; $display("FAIL wh_lock c%0d: got grant=%b rdy=%b want %b", c, grant_oh, bus.in_ready, exp_g); end
      if (c >= 1 && c <= 4) begin
        checks++; if (bus.out_flit !== flit_val(1, c - 1)) begin
          errors++; $display("FAIL wh_flit c%0d: got %h want %h", c, bus.out_flit, flit_val(1, c - 1)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(2, 1'b1, 1'b1, 1'b0, flit_val(2, 0));
    next_cycle();
    sample();
    checks++; if (grant_oh !== 5'b00100) begin errors++; $display("FAIL bp_grant: got %b want 00100", grant_oh); end
    next_cycle();
    drive(2, 1'b1, 1'b0, 1'b0, flit_val(2, 1));
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      sample();
      checks++; if (grant_oh !== 5'b00100 || bus.out_valid !== 1'b1 || bus.out_flit !== flit_val(2, 1) ||
                    bus.in_ready !== 5'b00000 || wdog_err !== 1'b0) begin
        errors++; $display("FAIL bp_hold c%0d: got grant=%b ov=%b flit=%h rdy=%b wd=%b want 00100 1 %h 00000 0",
                           c, grant_oh, bus.out_valid, bus.out_flit, bus.in_ready, wdog_err, flit_val(2, 1)); end
      next_cycle();
    end
    bus.out_ready = 1'b1;
    sample();
    checks++; if (bus.in_ready !== 5'b00100) begin errors++; $display("FAIL bp_release: got %b want 00100", bus.in_ready); end
    next_cycle();
    drive(2, 1'b1, 1'b0, 1'b1, flit_val(2, 2));
    next_cycle();
    drive(2, 1'b0, 1'b0, 1'b0, '0);
    sample();
    checks++; if (grant_oh !== 5'b00000) begin errors++; $display("FAIL bp_done: got %b want 00000", grant_oh); end
  endtask

`ifdef NOC_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    drive(2, 1'b1, 1'b1, 1'b0, flit_val(2, 0));
    next_cycle();
    sample();
    checks++; if (grant_oh !== 5'b00100) begin errors++; $display("FAIL wd_grant: got %b want 00100", grant_oh); end
    next_cycle();
    drive(2, 1'b0, 1'b0, 1'b0, '0);
    for (int c = 0; c < WD; c++) begin
      sample();
      checks++; if (grant_oh !== 5'b00100 || wdog_err !== 1'b0) begin
        errors++; $display("FAIL wd_stall c%0d: got grant=%b wd=%b want 00100 0", c, grant_oh, wdog_err); end
      next_cycle();
    end
    drive(0, 1'b1, 1'b1, 1'b1, flit_val(0, 0));
    drive(2, 1'b1, 1'b1, 1'b1, flit_val(2, 9));
    drive(4, 1'b1, 1'b1, 1'b1, flit_val(4, 0));
    sample();
    checks++; if (grant_oh !== 5'b00000 || wdog_err !== 1'b1) begin
      errors++; $display("FAIL wd_fire: got grant=%b wd=%b want 00000 1", grant_oh, wdog_err); end
    next_cycle();
    sample();
    checks++; if (grant_oh !== 5'b10000 || wdog_err !== 1'b0) begin
      errors++; $display("FAIL wd_next: got grant=%b wd=%b want 10000 0", grant_oh, wdog_err); end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid_packet();
    do_reset();
    drive(3, 1'b1, 1'b1, 1'b1, flit_val(3, 0));
    next_cycle();
    next_cycle();
    drive(3, 1'b0, 1'b0, 1'b0, '0);
    drive(1, 1'b1, 1'b1, 1'b0, flit_val(1, 0));
    next_cycle();
    sample();
    checks++; if (grant_oh !== 5'b00010) begin errors++; $display("FAIL rmp_lock: got %b want 00010", grant_oh); end
    next_cycle();
    drive(1, 1'b1, 1'b0, 1'b0, flit_val(1, 1));
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, 1'b1, flit_val(i, 5));
    sample();
    checks++; if (grant_oh !== 5'b00000 || bus.out_valid !== 1'b0 || bus.in_ready !== 5'b00000) begin
      errors++; $display("FAIL rmp_idle: got grant=%b ov=%b rdy=%b want 00000 0 00000", grant_oh, bus.out_valid, bus.in_ready); end
    next_cycle();
    sample();
    checks++; if (grant_oh !== 5'b00001) begin errors++; $display("FAIL rmp_rrptr: got %b want 00001", grant_oh); end
    idle_inputs();
  endtask

  // Packet-level reference: each input owns an endless stream of packets of random length.
  task automatic test_random();
    int len [N];
    int pos [N];
    int stall [N];
    logic v [N];
    logic h [N];
    logic t [N];
    logic [W-1:0] f [N];
    logic ordy;
    int m_owner;
    int m_ptr;
    logic [N-1:0] exp_g, exp_r;
    do_reset();
    m_owner = -1;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) begin
      len[i] = 1 + $urandom_range(3);
      pos[i] = 0;
      stall[i] = 0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        f[i] = {16'(i), 16'(pos[i]), 32'($urandom)};
        if (pos[i] == 0) begin
          v[i] = ($urandom_range(1) == 1) || (stall[i] >= 3);
          h[i] = 1'b1;
          if (!v[i] && m_owner != i && $urandom_range(3) == 0) begin
            v[i] = 1'b1;
            h[i] = 1'b0;
          end
        end else begin
          v[i] = ($urandom_range(3) != 0) || (stall[i] >= 3);
          h[i] = ($urandom_range(7) == 0);
        end
        t[i] = (pos[i] == len[i] - 1);
        if (!v[i]) begin
          h[i] = 1'($urandom_range(1));
          t[i] = 1'($urandom_range(1));
        end
        drive(i, v[i], h[i], t[i], f[i]);
        stall[i] = v[i] ? 0 : stall[i] + 1;
      end
      ordy = ($urandom_range(3) != 0);
      bus.out_ready = ordy;
      sample();
      exp_g = '0;
      exp_r = '0;
      if (m_owner >= 0) begin
        exp_g[m_owner] = 1'b1;
        exp_r[m_owner] = ordy;
      end
      checks++; if (grant_oh !== exp_g || bus.in_ready !== exp_r) begin
        errors++; $display("FAIL rnd_grant c%0d: got grant=%b rdy=%b want grant=%b rdy=%b", c, grant_oh, bus.in_ready, exp_g, exp_r); end
      checks++; if (bus.out_valid !== ((m_owner >= 0) ? v[m_owner] : 1'b0) || wdog_err !== 1'b0) begin
        errors++; $display("FAIL rnd_valid c%0d: got ov=%b wd=%b want ov=%b wd=0", c, bus.out_valid, wdog_err,
                           (m_owner >= 0) ? v[m_owner] : 1'b0); end
      if (m_owner >= 0) begin
        checks++; if (bus.out_flit !== f[m_owner]) begin
          errors++; $display("FAIL rnd_flit c%0d: got %h want %h", c, bus.out_flit, f[m_owner]); end
      end
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (m_owner < 0 && v[idx] && h[idx]) m_owner = idx;
        end
      end else if (v[m_owner] && ordy) begin
        if (pos[m_owner] == len[m_owner] - 1) begin
          pos[m_owner] = 0;
          len[m_owner] = 1 + $urandom_range(3);
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end else begin
          pos[m_owner]++;
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_flit();
    test_round_robin();
    test_wormhole();
    test_backpressure();
`ifdef NOC_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
